fpga_rst_seq: RTL and testbench
===============================

Name: fpga_rst_seq

Overview:
Parametrised reset sequencer for FPGA board tops. It sits between the clock wizard / board pads and the SoC core(s), filtering the PLL-lock and reset-button inputs. It releases NUM_CH active-low reset domains in a fixed order with programmable gaps, re-enters reset on PLL loss, button press or software request, and records the cause of the last reset.

Parameters:
NUM_CH, 3, number of sequenced reset outputs (1..16); bit 0 is released first.
SYNC_STAGES, 2, synchroniser flops on each asynchronous input (>=2).
DEBOUNCE_CYC, 50000, consecutive stable cycles required before the filtered button changes (>=1).
LOCK_WAIT_CYC, 1024, consecutive cycles of (locked & button released) required in HOLD before sequencing starts (>=1).
GAP_CYC, 64, cycles between successive channel releases (>=1).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  synchronous, active-high reset.
pll_locked_i  in  1  PLL lock; asynchronous, high = locked.
btn_rst_n_i  in  1  board reset button; asynchronous, low = pressed.
sw_rst_req_i  in  1  software reset request; single-cycle pulse in the clk_i domain.
rst_n_o  out  NUM_CH  sequenced active-low resets, all registered.
all_rel_o  out  1  high when every channel is released.
state_o  out  2  FSM state (0 HOLD, 1 RELEASE, 2 RUN).
rst_cause_o  out  2  last reset cause (0 POR, 1 PLL lost, 2 button, 3 software); sticky.

Behaviour:
- Reset (rst_i=1 at an edge): state HOLD, rst_n_o=0, all_rel_o=0, rst_cause_o=0, all counters 0.
  - Reset values: filtered lock 0, filtered button 1, all synchroniser flops at the same values.
- Input filter, per input:
  - Input passes through SYNC_STAGES flops.
  - Filtered output takes the synchronised value once it has differed from the output for STABLE consecutive cycles. Any return to equality clears the counter.
  - STABLE = DEBOUNCE_CYC for the button, 1 for lock.
- Latency: PLL loss reaches rst_n_o=0 on edge SYNC_STAGES+2, counting the first edge that samples pll_locked_i=0 as edge 1.
- HOLD:
  - All rst_n_o=0.
  - wait_cnt increments while filtered lock=1 and filtered button=1; otherwise it clears to 0.
  - When wait_cnt reaches LOCK_WAIT_CYC-1 and the condition still holds, go to RELEASE with idx=0 and gap_cnt=0.
  - sw_rst_req_i is ignored in HOLD, and rst_cause_o is unchanged.
- RELEASE:
  - gap_cnt counts 0..GAP_CYC-1.
  - At GAP_CYC-1: set rst_n_o[idx]=1, increment idx, clear gap_cnt.
  - Channel k rises exactly (k+1)*GAP_CYC cycles after the edge that entered RELEASE.
  - On releasing idx=NUM_CH-1: go to RUN and set all_rel_o=1 on the same edge.
- RUN: all rst_n_o=1 and all_rel_o=1.
- Fault, in RELEASE or RUN:
  - A fault is filtered lock=0, filtered button=0, or sw_rst_req_i=1.
  - On the next edge: state HOLD, all rst_n_o=0, all_rel_o=0, counters and idx cleared.
  - rst_cause_o is updated on the same edge.
  - Simultaneous faults use priority PLL (1) > button (2) > software (3).
- Released channels never re-assert individually; a fault always drops all channels together.
- Unused state encoding 3 goes to HOLD with all outputs low.
- rst_i mid-sequence: immediate return to reset values, and cause returns to POR.
- Counter widths: $clog2(max count + 1). idx width: $clog2(NUM_CH+1).

Decomposition:
- Package fpga_rst_pkg holds:
  - the state localparams (HOLD/RELEASE/RUN);
  - the cause codes (POR/PLL/BTN/SW);
  - the counter-width function.
- One sub-module, rst_in_filter (parameters SYNC_STAGES, STABLE_CYC, RST_VAL), is instantiated twice: for the button and for lock.

Test Plan:
Bench parameters: NUM_CH=3, SYNC_STAGES=2, DEBOUNCE_CYC=8, LOCK_WAIT_CYC=4, GAP_CYC=3.
1. Power-up: rst_i for 5 cycles, then lock=1 and button high.
   -> rst_n_o goes 000 -> 001 -> 011 -> 111 at exactly 3-cycle spacing after state_o=1.
   -> all_rel_o=1 on the same edge as 111; rst_cause_o=0.
2. In RUN, drop pll_locked_i.
   -> rst_n_o=000 and state_o=0 on the 4th edge; rst_cause_o=1.
   -> Resequences only after lock is high for 4 filtered cycles.
3. Button glitch: low for 7 cycles -> no change.
   Button low for 8 or more cycles -> reset, rst_cause_o=2.
4. sw_rst_req_i pulse during RELEASE with rst_n_o=001 -> next edge rst_n_o=000, rst_cause_o=3.
   The same pulse in HOLD -> ignored, cause unchanged.
5. Same-cycle filtered lock loss and sw_rst_req_i in RUN -> rst_cause_o=1.
6. rst_i asserted mid-RELEASE -> all outputs return to reset values on that edge, rst_cause_o=0.

Source files
------------

// File: rtl/fpga_rst_pkg.sv
// Shared definitions for the FPGA reset sequencer.
//   ST_*      : FSM state codes, also driven out on state_o
//   CAUSE_*   : reset-cause codes reported on rst_cause_o
//   cnt_width : width of a counter that must hold 0..max_cnt (at least 1 bit)
package fpga_rst_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_BTN = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  // A max count of 0 still needs one bit so the counter declaration stays legal.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/rst_in_filter.sv
// Synchroniser plus stability filter for one asynchronous board input.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset; all flops load RST_VAL
//   async_i : raw asynchronous input
//   filt_o  : filtered level; follows the synchronised input only after it
//             has differed from filt_o for STABLE_CYC consecutive cycles
module rst_in_filter
  import fpga_rst_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CYC  = 1,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic filt_o
);

  localparam int            CW       = cnt_width(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // cnt_q holds how many earlier consecutive cycles already differed, so the
  // change is taken on the STABLE_CYC-th differing cycle.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      filt_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/fpga_rst_seq.sv
// Reset sequencer for FPGA board tops.
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   pll_locked_i : asynchronous PLL lock, high = locked
//   btn_rst_n_i  : asynchronous board reset button, low = pressed
//   sw_rst_req_i : single-cycle software reset request
//   rst_n_o      : active-low reset per domain, bit 0 released first
//   all_rel_o    : every domain released
//   state_o      : HOLD / RELEASE / RUN
//   rst_cause_o  : sticky cause of the last reset (POR/PLL/BTN/SW)
//
// state   | meaning
// HOLD    | all domains in reset, waiting for lock & button released
// RELEASE | releasing domains one by one, GAP_CYC apart
// RUN     | all domains released, watching for faults
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int LOCK_WAIT_CYC = 1024,
  parameter int GAP_CYC       = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pll_locked_i,
  input  logic              btn_rst_n_i,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              all_rel_o,
  output logic [1:0]        state_o,
  output logic [1:0]        rst_cause_o
);

  localparam int            WW        = cnt_width(LOCK_WAIT_CYC - 1);
  localparam int            GW        = cnt_width(GAP_CYC - 1);
  localparam int            IW        = cnt_width(NUM_CH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_WAIT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  logic lock_f, btn_f;

  rst_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (1),
    .RST_VAL    (1'b0)
  ) u_lock_filt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(pll_locked_i),
    .filt_o (lock_f)
  );

  rst_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (DEBOUNCE_CYC),
    .RST_VAL    (1'b1)
  ) u_btn_filt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(btn_rst_n_i),
    .filt_o (btn_f)
  );

  logic [1:0]        state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              all_rel_q, all_rel_d;
  logic [1:0]        cause_q, cause_d;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    all_rel_d = all_rel_q;
    cause_d   = cause_q;
    case (state_q)
      ST_HOLD: begin
        rst_n_d   = '0;
        all_rel_d = 1'b0;
        if (lock_f && btn_f) begin
          if (wait_q == WAIT_LAST) begin
            state_d = ST_RELEASE;
            wait_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          wait_d = '0;
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!lock_f || !btn_f || sw_rst_req_i) begin
          state_d   = ST_HOLD;
          rst_n_d   = '0;
          all_rel_d = 1'b0;
          wait_d    = '0;
          gap_d     = '0;
          idx_d     = '0;
          // Simultaneous faults report the most fundamental one first.
          if (!lock_f)     cause_d = CAUSE_PLL;
          else if (!btn_f) cause_d = CAUSE_BTN;
          else             cause_d = CAUSE_SW;
        end else if (state_q == ST_RELEASE) begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            idx_d = idx_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx_q == IW'(k)) rst_n_d[k] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              state_d   = ST_RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end else begin
          rst_n_d   = '1;
          all_rel_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_HOLD;
        rst_n_d   = '0;
        all_rel_d = 1'b0;
        wait_d    = '0;
        gap_d     = '0;
        idx_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_HOLD;
      wait_q    <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rst_n_q   <= '0;
      all_rel_q <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      all_rel_q <= all_rel_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign all_rel_o   = all_rel_q;
  assign state_o     = state_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
module tb_fpga_rst_seq;

  localparam int NUM_CH = 3;
  localparam int SYNC   = 2;
  localparam int DEB    = 8;
  localparam int LW     = 4;
  localparam int GAP    = 3;

  logic              clk = 1'b0;
  logic              rst, lock, btn, sw;
  logic [NUM_CH-1:0] rst_n;
  logic              all_rel;
  logic [1:0]        state, cause;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  fpga_rst_seq #(
    .NUM_CH       (NUM_CH),
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_CYC (DEB),
    .LOCK_WAIT_CYC(LW),
    .GAP_CYC      (GAP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pll_locked_i(lock),
    .btn_rst_n_i (btn),
    .sw_rst_req_i(sw),
    .rst_n_o     (rst_n),
    .all_rel_o   (all_rel),
    .state_o     (state),
    .rst_cause_o (cause)
  );

  // Reference model: inputs seen SYNC edges late, button accepted after DEB
  // consecutive contrary samples, sequencing tracked as elapsed time.
  bit m_pl[SYNC];
  bit m_pb[SYNC];
  bit m_fl, m_fb;
  bit m_hb[$];
  int m_phase;   // 0 hold, 1 release, 2 run
  int m_okrun;   // consecutive ok cycles seen in hold
  int m_t;       // cycles since release phase began
  int m_cause;

  function void model_reset();
    for (int i = 0; i < SYNC; i++) begin
      m_pl[i] = 1'b0;
      m_pb[i] = 1'b1;
    end
    m_fl = 1'b0;
    m_fb = 1'b1;
    m_hb.delete();
    m_phase = 0;
    m_okrun = 0;
    m_t     = 0;
    m_cause = 0;
  endfunction

  function void model_step(input bit r, input bit l, input bit b, input bit s);
    bit vl, vb, all_diff;
    if (r) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      if (m_fl && m_fb) begin
        m_okrun++;
        if (m_okrun == LW) begin
          m_phase = 1;
          m_t     = 0;
        end
      end else begin
        m_okrun = 0;
      end
    end else if (!m_fl || !m_fb || s) begin
      m_cause = !m_fl ? 1 : (!m_fb ? 2 : 3);
      m_phase = 0;
      m_okrun = 0;
    end else if (m_phase == 1) begin
      m_t++;
      if (m_t == NUM_CH * GAP) m_phase = 2;
    end
    vl = m_pl[SYNC-1];
    vb = m_pb[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) begin
      m_pl[i] = m_pl[i-1];
      m_pb[i] = m_pb[i-1];
    end
    m_pl[0] = l;
    m_pb[0] = b;
    m_fl = vl;
    m_hb.push_back(vb);
    if (m_hb.size() > DEB) m_hb.delete(0);
    if (m_hb.size() == DEB) begin
      all_diff = 1'b1;
      foreach (m_hb[i]) if (m_hb[i] == m_fb) all_diff = 1'b0;
      if (all_diff) m_fb = !m_fb;
    end
  endfunction

  function int exp_rstn();
    if (m_phase == 0) return 0;
    if (m_phase == 2) return (1 << NUM_CH) - 1;
    return (1 << (m_t / GAP)) - 1;
  endfunction

  task automatic check(input string name, input int tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, lock, btn, sw);
    @(negedge clk);
    cyc++;
    check("model_state", cyc, int'(state), m_phase);
    check("model_rst_n", cyc, int'(rst_n), exp_rstn());
    check("model_all_rel", cyc, int'(all_rel), (m_phase == 2) ? 1 : 0);
    check("model_cause", cyc, int'(cause), m_cause);
  endtask

  typedef struct {
    bit rst;
    bit lock;
    bit btn;
    bit sw;
    int ncyc;
    int st;
    int rstn;
    int arel;
    int cause;
  } vec_t;

  vec_t tv[$];

  function void add(input bit r, input bit l, input bit b, input bit s, input int n,
                    input int st, input int rn, input int ar, input int ca);
    vec_t v;
    v.rst = r; v.lock = l; v.btn = b; v.sw = s; v.ncyc = n;
    v.st = st; v.rstn = rn; v.arel = ar; v.cause = ca;
    tv.push_back(v);
  endfunction

  int press;

  initial begin
    // rst lock btn sw  n   state rst_n all_rel cause
    add(1, 0, 1, 0,  5,  0, 0, 0, 0);  // reset
    add(0, 1, 1, 0,  6,  0, 0, 0, 0);  // lock filtering + wait
    add(0, 1, 1, 0,  1,  1, 0, 0, 0);  // enter RELEASE
    add(0, 1, 1, 0,  2,  1, 0, 0, 0);
    add(0, 1, 1, 0,  1,  1, 1, 0, 0);  // ch0 at 3 cycles
    add(0, 1, 1, 0,  2,  1, 1, 0, 0);
    add(0, 1, 1, 0,  1,  1, 3, 0, 0);  // ch1 at 6
    add(0, 1, 1, 0,  2,  1, 3, 0, 0);
    add(0, 1, 1, 0,  1,  2, 7, 1, 0);  // ch2 + all_rel at 9
    add(0, 1, 1, 0,  4,  2, 7, 1, 0);
    add(0, 0, 1, 0,  3,  2, 7, 1, 0);  // PLL loss, 3 edges still running
    add(0, 0, 1, 0,  1,  0, 0, 0, 1);  // 4th edge drops everything
    add(0, 1, 1, 0,  6,  0, 0, 0, 1);
    add(0, 1, 1, 0,  1,  1, 0, 0, 1);
    add(0, 1, 1, 0,  3,  1, 1, 0, 1);
    add(0, 1, 1, 1,  1,  0, 0, 0, 3);  // sw request in RELEASE
    add(0, 1, 1, 1,  1,  0, 0, 0, 3);  // sw request in HOLD ignored
    add(0, 1, 1, 0,  2,  0, 0, 0, 3);
    add(0, 1, 1, 0,  1,  1, 0, 0, 3);
    add(0, 1, 1, 0,  9,  2, 7, 1, 3);
    add(0, 1, 0, 0,  7,  2, 7, 1, 3);  // 7-cycle glitch
    add(0, 1, 1, 0, 12,  2, 7, 1, 3);
    add(0, 1, 0, 0,  8,  2, 7, 1, 3);  // 8-cycle press
    add(0, 1, 1, 0,  2,  2, 7, 1, 3);
    add(0, 1, 1, 0,  1,  0, 0, 0, 2);
    add(0, 1, 1, 0, 25,  2, 7, 1, 2);
    add(0, 0, 1, 0,  3,  2, 7, 1, 2);
    add(0, 0, 1, 1,  1,  0, 0, 0, 1);  // lock loss + sw together
    add(0, 1, 1, 0, 10,  1, 1, 0, 1);
    add(1, 1, 1, 0,  1,  0, 0, 0, 0);  // rst mid-RELEASE
    add(0, 1, 1, 0, 16,  2, 7, 1, 0);

    rst = 1'b1; lock = 1'b0; btn = 1'b1; sw = 1'b0;
    model_reset();

    foreach (tv[i]) begin
      rst  = tv[i].rst;
      lock = tv[i].lock;
      btn  = tv[i].btn;
      sw   = tv[i].sw;
      repeat (tv[i].ncyc) tick();
      check("tv_state", i, int'(state), tv[i].st);
      check("tv_rst_n", i, int'(rst_n), tv[i].rstn);
      check("tv_all_rel", i, int'(all_rel), tv[i].arel);
      check("tv_cause", i, int'(cause), tv[i].cause);
    end

    rst = 1'b0; lock = 1'b1; btn = 1'b1; sw = 1'b0;
    press = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      sw  = ($urandom_range(0, 49) == 0);
      if (lock) lock = ($urandom_range(0, 59) != 0);
      else      lock = ($urandom_range(0, 4) == 0);
      if (press == 0 && $urandom_range(0, 79) == 0) press = $urandom_range(1, 14);
      btn = (press == 0);
      if (press > 0) press--;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
